// File: rtl/frame_buf_sched.sv
// frame_buf_sched
// Ping-pong frame buffer scheduler. The writer side turns the incoming pixel
// stream into write strobes and linear addresses for one bank. The reader side
// serves display line requests from the other bank. The banks swap once a full
// frame is written and the displayed frame has been completely read (or nothing
// has been displayed yet).
module frame_buf_sched #(
   parameter int PX_PER_LINE = 330,
   parameter int LINES       = 110,
   parameter int ADDR_W      = 16,
   parameter int LINE_W      = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   input  logic              sof,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              wr_bank,
   input  logic              line_req,
   input  logic [LINE_W-1:0] line_num,
   output logic              rd_en,
   output logic [LINE_W-1:0] rd_line,
   output logic              rd_bank,
   output logic              line_ack,
   output logic              line_err,
   output logic              frame_done,
   output logic              bank_swap,
   output logic              overflow
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PX_PER_LINE * LINES - 1);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

   typedef enum logic [1:0] {
      W_IDLE,
      W_FILL,
      W_DONE
   } wState_t;

   // R_EWAIT holds a rejected request for one extra cycle so that rejections
   // are acknowledged with the same latency as real reads.
   typedef enum logic [2:0] {
      R_IDLE,
      R_READ,
      R_ACK,
      R_EWAIT,
      R_ERR
   } rState_t;

   wState_t           wState;
   rState_t           rState;
   logic [ADDR_W-1:0] nextAddr;
   logic [ADDR_W-1:0] pixAddr;
   logic              dispValid;
   logic              rdDone;
   logic              swapNow;

   // A swap is only considered while the reader is idle, so it never cuts a
   // line read in half; it also wins over a request arriving in that cycle.
   assign swapNow = (rState == R_IDLE) && (wState == W_DONE) && (rdDone || !dispValid);

   // A start-of-frame pixel always lands at address 0, otherwise at the running address.
   assign pixAddr = sof ? '0 : nextAddr;

   // Writer: registers each accepted pixel with its address, flags drops and the final pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wState     <= W_IDLE;
         nextAddr   <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         case (wState)
            W_IDLE: begin
               if (pix_valid) begin
                  if (sof) begin
                     wr_en    <= 1'b1;
                     wr_addr  <= '0;
                     wr_data  <= pix_data;
                     nextAddr <= ADDR_W'(1);
                     wState   <= W_FILL;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            W_FILL: begin
               if (pix_valid) begin
                  wr_en    <= 1'b1;
                  wr_addr  <= pixAddr;
                  wr_data  <= pix_data;
                  nextAddr <= pixAddr + 1'b1;
                  if (pixAddr == LAST_ADDR) begin
                     frame_done <= 1'b1;
                     wState     <= W_DONE;
                  end
               end
            end
            W_DONE: begin
               if (pix_valid) begin
                  overflow <= 1'b1;
               end
               if (swapNow) begin
                  wState <= W_IDLE;
               end
            end
            default: wState <= W_IDLE;
         endcase
      end
   end

   // Reader and bank ownership: serves line requests and performs the bank swap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rState    <= R_IDLE;
         rd_en     <= 1'b0;
         rd_line   <= '0;
         line_ack  <= 1'b0;
         line_err  <= 1'b0;
         bank_swap <= 1'b0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b1;
         dispValid <= 1'b0;
         rdDone    <= 1'b0;
      end else begin
         rd_en     <= 1'b0;
         line_ack  <= 1'b0;
         line_err  <= 1'b0;
         bank_swap <= 1'b0;
         case (rState)
            R_IDLE: begin
               if (swapNow) begin
                  wr_bank   <= ~wr_bank;
                  rd_bank   <= ~rd_bank;
                  dispValid <= 1'b1;
                  rdDone    <= 1'b0;
                  bank_swap <= 1'b1;
               end else if (line_req) begin
                  if (!dispValid || (line_num > LAST_LINE)) begin
                     rState <= R_EWAIT;
                  end else begin
                     rd_line <= line_num;
                     rState  <= R_READ;
                  end
               end
            end
            R_READ: begin
               rd_en  <= 1'b1;
               rState <= R_ACK;
            end
            R_ACK: begin
               line_ack <= 1'b1;
               if (rd_line == LAST_LINE) begin
                  rdDone <= 1'b1;
               end
               rState <= R_IDLE;
            end
            R_EWAIT: begin
               rState <= R_ERR;
            end
            R_ERR: begin
               line_ack <= 1'b1;
               line_err <= 1'b1;
               rState   <= R_IDLE;
            end
            default: rState <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched
// Randomized bench for frame_buf_sched. A reference model indexed by clock
// edge count predicts every output from the pixel counts, scheduled read
// events and frame ownership rules; the DUT is compared against it each cycle.
module tb_frame_buf_sched;

   localparam int PX_PER_LINE = 330;
   localparam int LINES       = 110;
   localparam int ADDR_W      = 16;
   localparam int LINE_W      = 10;
   localparam int FRAME       = PX_PER_LINE * LINES;

   logic              clk = 1'b0;
   logic              reset;
   logic              pix_valid;
   logic [7:0]        pix_data;
   logic              sof;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_bank;
   logic              line_req;
   logic [LINE_W-1:0] line_num;
   logic              rd_en;
   logic [LINE_W-1:0] rd_line;
   logic              rd_bank;
   logic              line_ack;
   logic              line_err;
   logic              frame_done;
   logic              bank_swap;
   logic              overflow;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int cyc = 0;
   bit inReset;
   bit frameStarted, frameFull, dispOk, lastLineRead;
   int pixIdx, bankW;
   int readerFreeAt, rdAt, ackAt;
   bit ackErr;
   int eRdLine, eWrAddr, eWrData;
   bit eWrEn, eFrameDone, eOvf, eSwap, eRdEn, eAck, eErr;
   bit acceptedNow;

   // Requester and observation state
   int reqMode = 0;
   int nextLine = 0;
   int obsSwap = 0, obsDone = 0, doneCyc = 0, swapCyc = 0;

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   frame_buf_sched #(
      .PX_PER_LINE(PX_PER_LINE),
      .LINES      (LINES),
      .ADDR_W     (ADDR_W),
      .LINE_W     (LINE_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .sof       (sof),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_bank   (wr_bank),
      .line_req  (line_req),
      .line_num  (line_num),
      .rd_en     (rd_en),
      .rd_line   (rd_line),
      .rd_bank   (rd_bank),
      .line_ack  (line_ack),
      .line_err  (line_err),
      .frame_done(frame_done),
      .bank_swap (bank_swap),
      .overflow  (overflow)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic modelReset();
      inReset      = 1'b1;
      frameStarted = 1'b0;
      frameFull    = 1'b0;
      dispOk       = 1'b0;
      lastLineRead = 1'b0;
      pixIdx       = 0;
      bankW        = 0;
      readerFreeAt = 0;
      rdAt         = -1;
      ackAt        = -1;
      ackErr       = 1'b0;
      eRdLine      = 0;
      eWrAddr      = 0;
      eWrData      = 0;
      eWrEn        = 1'b0;
      eFrameDone   = 1'b0;
      eOvf         = 1'b0;
      eSwap        = 1'b0;
      eRdEn        = 1'b0;
      eAck         = 1'b0;
      eErr         = 1'b0;
      acceptedNow  = 1'b0;
   endtask

   task automatic modelStep();
      bit swapNow;
      int a;
      cyc++;
      eWrEn       = 1'b0;
      eFrameDone  = 1'b0;
      eSwap       = 1'b0;
      eRdEn       = 1'b0;
      eAck        = 1'b0;
      eErr        = 1'b0;
      acceptedNow = 1'b0;
      if (inReset) return;
      swapNow = (cyc >= readerFreeAt) && frameFull && (lastLineRead || !dispOk);
      if (pix_valid) begin
         if (frameFull || (!frameStarted && !sof)) begin
            eOvf = 1'b1;
         end else begin
            a            = sof ? 0 : pixIdx;
            eWrEn        = 1'b1;
            eWrAddr      = a;
            eWrData      = pix_data;
            pixIdx       = a + 1;
            frameStarted = 1'b1;
            if (a == FRAME - 1) begin
               eFrameDone = 1'b1;
               frameFull  = 1'b1;
            end
         end
      end
      if (cyc == rdAt) eRdEn = 1'b1;
      if (cyc == ackAt) begin
         eAck = 1'b1;
         eErr = ackErr;
         if (!ackErr && eRdLine == LINES - 1) lastLineRead = 1'b1;
      end
      if (swapNow) begin
         bankW        = bankW ^ 1;
         dispOk       = 1'b1;
         lastLineRead = 1'b0;
         frameFull    = 1'b0;
         frameStarted = 1'b0;
         pixIdx       = 0;
         eSwap        = 1'b1;
      end else if (cyc >= readerFreeAt && line_req) begin
         acceptedNow = 1'b1;
         ackErr      = !dispOk || (line_num >= LINES);
         if (!ackErr) begin
            eRdLine = line_num;
            rdAt    = cyc + 1;
         end
         ackAt        = cyc + 2;
         readerFreeAt = cyc + 3;
      end
   endtask

   task automatic checkAll();
      checkOutput("wr_en", wr_en, eWrEn);
      if (eWrEn) begin
         checkOutput("wr_addr", wr_addr, eWrAddr);
         checkOutput("wr_data", wr_data, eWrData);
      end
      checkOutput("frame_done", frame_done, eFrameDone);
      checkOutput("overflow", overflow, eOvf);
      checkOutput("bank_swap", bank_swap, eSwap);
      checkOutput("wr_bank", wr_bank, bankW);
      checkOutput("rd_bank", rd_bank, bankW ^ 1);
      checkOutput("rd_en", rd_en, eRdEn);
      checkOutput("line_ack", line_ack, eAck);
      checkOutput("line_err", line_err, eErr);
      checkOutput("rd_line", rd_line, eRdLine);
      if (frame_done === 1'b1) begin
         obsDone++;
         doneCyc = cyc;
      end
      if (bank_swap === 1'b1) begin
         obsSwap++;
         swapCyc = cyc;
      end
   endtask

   function automatic int pickLine();
      if ($urandom_range(0, 7) == 0) return LINES + int'($urandom_range(0, 1023 - LINES));
      if (reqMode == 2) return nextLine;
      return int'($urandom_range(0, LINES - 2));
   endfunction

   // Drives one cycle of pixel and request inputs, then advances model and checks.
   task automatic applyStimulus(input bit pv, input bit sf);
      pix_valid = pv;
      sof       = sf;
      pix_data  = 8'($urandom);
      if (eAck) begin
         if (reqMode == 2 && !eErr) nextLine++;
         line_req = 1'b0;
      end
      if (!line_req && reqMode != 0 && !(reqMode == 2 && nextLine >= LINES)
          && $urandom_range(0, 3) != 0) begin
         line_req = 1'b1;
         line_num = LINE_W'(pickLine());
      end
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   initial begin
      int sent;
      int lastPixCyc;
      reset     = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      sof       = 1'b0;
      line_req  = 1'b0;
      line_num  = '0;
      modelReset();

      @(negedge clk);
      checkAll();
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_wr_data", wr_data, 0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      reset   = 1'b1;
      inReset = 1'b0;
      $display("[TB] reset released, frame 1 back-to-back with pre-swap requests");

      reqMode    = 1;
      lastPixCyc = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (i == FRAME - 20) reqMode = 0;
         applyStimulus(1'b1, i == 0);
      end
      lastPixCyc = cyc;
      for (int k = 0; k < 50 && obsSwap < 1; k++) applyStimulus(1'b0, 1'b0);
      checkOutput("f1_done_count", obsDone, 1);
      checkOutput("f1_done_on_last_write", doneCyc - lastPixCyc, 0);
      checkOutput("f1_swap_count", obsSwap, 1);
      checkOutput("f1_swap_after_done", swapCyc - doneCyc, 1);
      checkOutput("f1_wr_bank", wr_bank, 1);
      checkOutput("f1_rd_bank", rd_bank, 0);

      $display("[TB] frame 2 with gaps and sof restart at pixel 500");
      reqMode = 1;
      sent    = 0;
      for (int g = 0; g < 60000 && sent < 500 + FRAME; g++) begin
         bit pv;
         pv = ($urandom_range(0, 15) != 0);
         applyStimulus(pv, pv && (sent == 0 || sent == 500));
         if (pv) sent++;
      end
      reqMode = 0;
      checkOutput("f2_done_count", obsDone, 2);
      checkOutput("f2_no_early_swap", obsSwap, 1);

      for (int k = 0; k < 16; k++) applyStimulus(k == 0 || $urandom_range(0, 1) == 1, 1'b0);
      checkOutput("ovf_in_done", overflow, 1);

      $display("[TB] reading lines 0..%0d", LINES - 1);
      reqMode  = 2;
      nextLine = 0;
      for (int k = 0; k < 3000 && obsSwap < 2; k++) applyStimulus(1'b0, 1'b0);
      reqMode = 0;
      checkOutput("f2_swap_count", obsSwap, 2);
      checkOutput("f2_wr_bank", wr_bank, 0);
      checkOutput("f2_rd_bank", rd_bank, 1);
      checkOutput("ovf_still_set", overflow, 1);

      $display("[TB] frame 3 interrupted by reset during a line read");
      reqMode = 1;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b1, i == 0);
         if (acceptedNow && i > 20) break;
      end
      reqMode   = 0;
      line_req  = 1'b0;
      pix_valid = 1'b0;
      sof       = 1'b0;
      reset     = 1'b0;
      #1;
      modelReset();
      checkAll();
      checkOutput("midrst_ovf", overflow, 0);
      checkOutput("midrst_rd_bank", rd_bank, 1);
      checkOutput("midrst_wr_en", wr_en, 0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      reset   = 1'b1;
      inReset = 1'b0;

      for (int i = 0; i < 40; i++) applyStimulus(1'b1, i == 0);
      checkOutput("post_rst_addr", wr_addr, 39);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
